// File: rtl/soc_sram_responder_if.sv
// CPU <-> SRAM responder bus: instruction port, data port, MMIO outputs and imem load port.
// master = CPU/bootloader side, slave = responder side.
interface soc_sram_responder_if #(
  parameter int IMEM_AW = 12
);
  logic [31:0]        iaddr;
  logic               ice;
  logic [31:0]        inst;
  logic [31:0]        daddr;
  logic               dce;
  logic [3:0]         we;
  logic [31:0]        din;
  logic [31:0]        dm;
  logic [5:0]         int_o;
  logic [15:0]        led;
  logic               prog_we;
  logic [IMEM_AW-1:0] prog_addr;
  logic [31:0]        prog_data;

  modport master (
    output iaddr, ice, daddr, dce, we, din, prog_we, prog_addr, prog_data,
    input  inst, dm, int_o, led
  );

  modport slave (
    input  iaddr, ice, daddr, dce, we, din, prog_we, prog_addr, prog_data,
    output inst, dm, int_o, led
  );
endinterface

// File: rtl/soc_sram_responder.sv
// SRAM-style imem/dmem responder with LED + count/compare timer MMIO; 1-cycle read latency, never stalls.
// Optional store counter at MMIO 0x10 is built when SOC_RESP_STCNT_EN is defined.
module soc_sram_responder #(
  parameter int          IMEM_AW      = 12,
  parameter int          DMEM_AW      = 12,
  parameter logic [15:0] MMIO_BASE_HI = 16'hBFAF
) (
  input logic                 cpu_clk_50M,
  input logic                 cpu_rst,
  soc_sram_responder_if.slave bus
);
  localparam logic [15:0] OFS_LED   = 16'h0000;
  localparam logic [15:0] OFS_COUNT = 16'h0004;
  localparam logic [15:0] OFS_CMP   = 16'h0008;
  localparam logic [15:0] OFS_CTRL  = 16'h000C;
  localparam logic [15:0] OFS_STCNT = 16'h0010;

  logic [31:0] r_imem [0:(1<<IMEM_AW)-1];
  logic [31:0] r_dmem [0:(1<<DMEM_AW)-1];

  logic [31:0] r_inst;
  logic [31:0] r_dm;
  logic [15:0] r_led;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_en;
  logic        r_pend;

  logic               w_is_mmio;
  logic [15:0]        w_ofs;
  logic               w_st;
  logic               w_ld;
  logic               w_ram_st;
  logic               w_wr_led;
  logic               w_wr_count;
  logic               w_wr_cmp;
  logic               w_wr_ctrl;
  logic               w_tmr_hit;
  logic               w_pend_clr;
  logic [31:0]        w_mmio_rd;
  logic [IMEM_AW-1:0] w_iidx;
  logic [DMEM_AW-1:0] w_didx;
  logic               w_unused;

`ifdef SOC_RESP_STCNT_EN
  logic [31:0] r_stcnt;
  logic        w_wr_stcnt;
`endif

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] v;
    for (int i = 0; i < 4; i++)
      v[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return v;
  endfunction

  always_comb begin
    w_iidx     = bus.iaddr[IMEM_AW+1:2];
    w_didx     = bus.daddr[DMEM_AW+1:2];
    w_is_mmio  = (bus.daddr[31:16] == MMIO_BASE_HI);
    w_ofs      = bus.daddr[15:0];
    w_st       = bus.dce && (bus.we != 4'b0000);
    w_ld       = bus.dce && (bus.we == 4'b0000);
    w_ram_st   = w_st && !w_is_mmio;
    w_wr_led   = w_st && w_is_mmio && (w_ofs == OFS_LED);
    w_wr_count = w_st && w_is_mmio && (w_ofs == OFS_COUNT);
    w_wr_cmp   = w_st && w_is_mmio && (w_ofs == OFS_CMP);
    w_wr_ctrl  = w_st && w_is_mmio && (w_ofs == OFS_CTRL);
    w_tmr_hit  = r_en && (r_count == r_compare);
    w_pend_clr = w_wr_ctrl && bus.we[0] && bus.din[1];
`ifdef SOC_RESP_STCNT_EN
    w_wr_stcnt = w_st && w_is_mmio && (w_ofs == OFS_STCNT);
`endif
    w_mmio_rd = 32'h0;
    case (w_ofs)
      OFS_LED:   w_mmio_rd = {16'h0, r_led};
      OFS_COUNT: w_mmio_rd = r_count;
      OFS_CMP:   w_mmio_rd = r_compare;
      OFS_CTRL:  w_mmio_rd = {30'h0, r_pend, r_en};
`ifdef SOC_RESP_STCNT_EN
      OFS_STCNT: w_mmio_rd = r_stcnt;
`endif
      default:   w_mmio_rd = 32'h0;
    endcase
  end

  // Memory arrays carry no reset so they map onto block RAM.
  always_ff @(posedge cpu_clk_50M) begin
    if (bus.prog_we)
      r_imem[bus.prog_addr] <= bus.prog_data;
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (w_ram_st && !cpu_rst) begin
      for (int i = 0; i < 4; i++)
        if (bus.we[i]) r_dmem[w_didx][8*i +: 8] <= bus.din[8*i +: 8];
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_inst    <= 32'h0;
      r_dm      <= 32'h0;
      r_led     <= 16'h0;
      r_count   <= 32'h0;
      r_compare <= 32'hFFFF_FFFF;
      r_en      <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      if (bus.ice) r_inst <= r_imem[w_iidx];
      if (w_ld)    r_dm   <= w_is_mmio ? w_mmio_rd : r_dmem[w_didx];
      if (w_wr_led && bus.we[0]) r_led[7:0]  <= bus.din[7:0];
      if (w_wr_led && bus.we[1]) r_led[15:8] <= bus.din[15:8];
      r_count <= w_wr_count ? merge_be(r_count, bus.din, bus.we) : r_count + 32'd1;
      if (w_wr_cmp) r_compare <= merge_be(r_compare, bus.din, bus.we);
      if (w_wr_ctrl && bus.we[0]) r_en <= bus.din[0];
      // Set beats a same-cycle write-1-clear.
      r_pend <= w_tmr_hit || (r_pend && !w_pend_clr);
    end
  end

`ifdef SOC_RESP_STCNT_EN
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst)
      r_stcnt <= 32'h0;
    else if (w_wr_stcnt)
      r_stcnt <= merge_be(r_stcnt, bus.din, bus.we);
    else if (w_st)
      r_stcnt <= r_stcnt + 32'd1;
  end
`endif

  assign bus.inst  = r_inst;
  assign bus.dm    = r_dm;
  assign bus.led   = r_led;
  assign bus.int_o = {r_pend, 5'b0};

  assign w_unused = &{1'b0, bus.iaddr[31:IMEM_AW+2], bus.iaddr[1:0]};
endmodule
